butterfly_pipe: RTL and testbench
=================================

# butterfly_pipe

- Pipelined radix-2 modular butterfly for the 2-BFU NTT datapath, q = 12289.
- Two instances (BFU 0 and BFU 1) drive `bf_0_upper`/`bf_0_lower` and `bf_1_upper`/`bf_1_lower` of the butterfly-output routing network.
- Fixed 7-cycle latency matches the 7-cycle delay the routing network applies to its bank selects. This alignment is the block's central timing contract.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) per sample; the mode travels with the data through the pipeline.

## Interface
Parameters:
- `data_width`, 14, coefficient width; must hold q−1.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `valid_in` input, 1 bit: marks a sample present on a/b/w/mode this cycle.
- `mode` input, 1 bit: 0 = CT (NTT), 1 = GS (INTT).
- `a` input, `data_width` bits: upper operand, in [0,q).
- `b` input, `data_width` bits: lower operand, in [0,q).
- `w` input, `data_width` bits: twiddle factor, in [0,q).
- `bf_upper` output, `data_width` bits: upper result, in [0,q).
- `bf_lower` output, `data_width` bits: lower result, in [0,q).
- `valid_out` output, 1 bit: `valid_in` delayed exactly 7 cycles.

## Operation
- Free-running pipeline: no stall and no backpressure. A new sample is accepted every cycle.
- Data registers load every cycle. When `valid_out` = 0, `bf_upper`/`bf_lower` carry don't-care values, except in the post-reset window (below).
- CT mode: `bf_upper` = (a + w·b) mod q; `bf_lower` = (a − w·b) mod q.
- GS mode: `bf_upper` = (a + b) mod q; `bf_lower` = ((a − b) mod q)·w mod q.
- Stage allocation:
  - S1: capture a/b/w/mode/valid. In GS, compute a+b and a−b mod q. Select the multiplier operand: b for CT, (a−b) for GS.
  - S2–S5: modular multiplier. 28-bit product, then Barrett reduction with m = floor(2^28/q) = 21843 and shift 28. The raw remainder is < 3q; at most two conditional subtractions of q bring it into [0,q).
  - S6: CT add/sub mod q; in GS, the optional halving.
  - S7: output registers.
- Operand a (CT) and the a+b sum (GS) are delayed through S2–S5 to align with the multiplier output.
- Modular add: if the sum ≥ q, subtract q. Modular subtract: if the difference is negative, add q. No intermediate wider than 28 bits, apart from the Barrett t·m product.
- Mode and valid are carried per stage, so alternating CT/GS samples on consecutive cycles produce independent, correct results.
- Inputs ≥ q violate the contract. The simulation-only check flags any valid sample with a, b or w ≥ q.

## Timing
- Latency: the sample presented at edge N appears on the outputs after edge N+7. `valid_out` follows the same delay.
- Throughput: 1 sample/cycle in both modes.
- Reset: on any rising edge with `rst` = 0, all stage registers clear.
  - `bf_upper`, `bf_lower` and `valid_out` read 0 from that edge.
  - They stay 0 until the first post-reset sample emerges 7 edges after it is presented.
- Reset mid-stream: in-flight samples are discarded with no partial outputs. A sample presented on the first cycle with `rst` = 1 emerges 7 cycles later.
- `valid_in` asserted while `rst` = 0 is ignored.

## Configuration
- `BFU_GS_DIV2_EN` defined: in GS mode, S6 halves both results mod q (x even → x>>1; x odd → (x+q)>>1). This folds the N⁻¹ INTT scaling into the butterflies. CT mode is unaffected.
- `BFU_GS_DIV2_EN` undefined: S6 passes GS results through unchanged.
- Latency is 7 in both builds.

## Structure
- Shared NTT package holds Q = 12289, BARRETT_M = 21843, BARRETT_SHIFT = 28, and the mode constants MODE_CT = 0 and MODE_GS = 1.
- One sub-module, `mod_mul_barrett`:
  - 4-stage pipelined (S2–S5) multiply plus Barrett reduction.
  - Inputs x, y < q; output x·y mod q.
  - Carries no valid signal; the parent delays valid and mode.

## Test plan
- CT, a=1, b=1, w=1 → 7 cycles later: upper=2, lower=0, valid_out=1.
- CT, a=0, b=1, w=12288 → upper=12288, lower=1.
- CT, a=b=w=12288 → upper=0, lower=12287 (exercises wrap-around on both add and subtract).
- GS, a=5, b=3, w=2 → upper=8, lower=4 without the macro; upper=4, lower=2 with `BFU_GS_DIV2_EN`.
- GS, a=3, b=5, w=1 with `BFU_GS_DIV2_EN` → upper=4, lower=12288 (odd halving path); 300 back-to-back random samples alternating CT/GS checked against a reference model.
- Stream valid samples, drop `rst` for one cycle mid-stream → outputs and `valid_out` read 0 from that edge; no stale results appear; the next sample emerges exactly 7 cycles after it is presented.

Source files
------------

// File: rtl/butterfly_pipe_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_pipe_pkg
// Shared constants for the NTT datapath (q = 12289).
//   Q             : NTT modulus
//   BARRETT_M     : floor(2^28 / Q), the Barrett reduction multiplier
//   BARRETT_SHIFT : Barrett shift amount
//   MODE_CT       : Cooley-Tukey butterfly (forward NTT)
//   MODE_GS       : Gentleman-Sande butterfly (inverse NTT)
// -----------------------------------------------------------------------------
package butterfly_pipe_pkg;

    localparam int unsigned Q             = 12289;
    localparam int unsigned BARRETT_M     = 21843;
    localparam int unsigned BARRETT_SHIFT = 28;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

endpackage

// File: rtl/butterfly_pipe_mod_mul_barrett.sv
// -----------------------------------------------------------------------------
// mod_mul_barrett
// Four-stage pipelined modular multiplier: z = x * y mod Q, via Barrett
// reduction. Pipeline stages correspond to butterfly stages S2..S5.
// Carries no valid; the parent delays its own sideband to match.
// Ports:
//   clk  in  : rising-edge clock
//   rst  in  : synchronous active-low reset, clears every stage register
//   x, y in  : operands, each < Q
//   z    out : x * y mod Q, 4 cycles after x/y are presented
// -----------------------------------------------------------------------------
module mod_mul_barrett
    import butterfly_pipe_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] z
);

    localparam int PW = 2 * W;      // full product width
    localparam int MW = PW + 16;    // width of the p * BARRETT_M product

    localparam logic [W+1:0] Q_R = (W + 2)'(Q);

    logic [PW-1:0] p2_q, p2_d;      // S2: raw product
    logic [PW-1:0] p3_q;            // S3: product carried alongside estimate
    logic [W-1:0]  est_q, est_d;    // S3: quotient estimate floor(p*m / 2^28)
    logic [W+1:0]  r_q, r_d;        // S4: raw remainder, < 3Q
    logic [W-1:0]  z_q, z_d;        // S5: fully reduced result
    logic [PW-1:0] tq;
    logic [W+1:0]  r1;

    always_comb begin
        p2_d  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        est_d = W'(({16'b0, p2_q} * MW'(BARRETT_M)) >> BARRETT_SHIFT);
        tq    = {{W{1'b0}}, est_q} * PW'(Q);
        // The estimate never exceeds the true quotient, so this cannot wrap
        // and the remainder is known to be below 3Q.
        r_d   = (W + 2)'(p3_q - tq);
        r1    = (r_q >= Q_R) ? r_q - Q_R : r_q;
        z_d   = W'((r1 >= Q_R) ? r1 - Q_R : r1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p2_q  <= '0;
            p3_q  <= '0;
            est_q <= '0;
            r_q   <= '0;
            z_q   <= '0;
        end else begin
            p2_q  <= p2_d;
            p3_q  <= p2_q;
            est_q <= est_d;
            r_q   <= r_d;
            z_q   <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/butterfly_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_pipe
// Pipelined radix-2 modular butterfly (q = 12289), fixed 7-cycle latency.
// CT: upper = a + w*b, lower = a - w*b          (mod q)
// GS: upper = a + b,   lower = (a - b) * w      (mod q)
// Mode and valid travel with each sample, so CT and GS may be interleaved.
// Free-running: one sample per cycle, no handshake and no backpressure;
// valid_in simply qualifies the inputs and valid_out qualifies the outputs.
// Build option:
//   BFU_GS_DIV2_EN : in GS mode both results are also halved mod q in S6.
// Ports:
//   clk       in  : rising-edge clock
//   rst       in  : synchronous active-low reset
//   valid_in  in  : sample present on a/b/w/mode
//   mode      in  : 0 = CT, 1 = GS
//   a, b, w   in  : upper operand, lower operand, twiddle (all < q)
//   bf_upper  out : upper result
//   bf_lower  out : lower result
//   valid_out out : valid_in delayed 7 cycles
// -----------------------------------------------------------------------------
module butterfly_pipe
    import butterfly_pipe_pkg::*;
#(
    parameter int data_width = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  mode,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [data_width-1:0] w,
    output logic [data_width-1:0] bf_upper,
    output logic [data_width-1:0] bf_lower,
    output logic                  valid_out
);

    localparam int W = data_width;
    localparam logic [W:0]   Q_E = (W + 1)'(Q);
    localparam logic [W-1:0] Q_N = W'(Q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_E) s = s - Q_E;
        return W'(s);
    endfunction

    // Operands are below q < 2^W, so bit W of the difference is its sign.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W]) d = d + Q_E;
        return W'(d);
    endfunction

`ifdef BFU_GS_DIV2_EN
    // x/2 mod q: odd values become even by adding q before the shift.
    function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x);
        logic [W:0] h;
        h = x[0] ? ({1'b0, x} + Q_E) : {1'b0, x};
        return W'(h >> 1);
    endfunction
`endif

    // S1
    logic         s1_valid_q, s1_mode_q;
    logic [W-1:0] s1_pass_q, s1_pass_d;     // a (CT) or a+b (GS)
    logic [W-1:0] s1_mulop_q, s1_mulop_d;   // b (CT) or a-b (GS)
    logic [W-1:0] s1_w_q;

    // S2..S5 sideband delay, index 3 lines up with the multiplier output
    logic [3:0]   dly_valid_q, dly_mode_q;
    logic [W-1:0] dly_pass_q [4];
    logic [W-1:0] mul_z;

    // S6 and S7
    logic         s6_valid_q, out_valid_q;
    logic [W-1:0] s6_up_q, s6_up_d, s6_lo_q, s6_lo_d;
    logic [W-1:0] out_up_q, out_lo_q;

    always_comb begin
        s1_pass_d  = (mode == MODE_GS) ? add_mod(a, b) : a;
        s1_mulop_d = (mode == MODE_GS) ? sub_mod(a, b) : b;
    end

    mod_mul_barrett #(.W(W)) u_mul (
        .clk (clk),
        .rst (rst),
        .x   (s1_mulop_q),
        .y   (s1_w_q),
        .z   (mul_z)
    );

    always_comb begin
        if (dly_mode_q[3] == MODE_GS) begin
`ifdef BFU_GS_DIV2_EN
            s6_up_d = halve_mod(dly_pass_q[3]);
            s6_lo_d = halve_mod(mul_z);
`else
            s6_up_d = dly_pass_q[3];
            s6_lo_d = mul_z;
`endif
        end else begin
            s6_up_d = add_mod(dly_pass_q[3], mul_z);
            s6_lo_d = sub_mod(dly_pass_q[3], mul_z);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_CT;
            s1_pass_q   <= '0;
            s1_mulop_q  <= '0;
            s1_w_q      <= '0;
            dly_valid_q <= '0;
            dly_mode_q  <= '0;
            for (int i = 0; i < 4; i++) dly_pass_q[i] <= '0;
            s6_valid_q  <= 1'b0;
            s6_up_q     <= '0;
            s6_lo_q     <= '0;
            out_valid_q <= 1'b0;
            out_up_q    <= '0;
            out_lo_q    <= '0;
        end else begin
            s1_valid_q  <= valid_in;
            s1_mode_q   <= mode;
            s1_pass_q   <= s1_pass_d;
            s1_mulop_q  <= s1_mulop_d;
            s1_w_q      <= w;
            dly_valid_q <= {dly_valid_q[2:0], s1_valid_q};
            dly_mode_q  <= {dly_mode_q[2:0], s1_mode_q};
            dly_pass_q[0] <= s1_pass_q;
            for (int i = 1; i < 4; i++) dly_pass_q[i] <= dly_pass_q[i-1];
            s6_valid_q  <= dly_valid_q[3];
            s6_up_q     <= s6_up_d;
            s6_lo_q     <= s6_lo_d;
            out_valid_q <= s6_valid_q;
            out_up_q    <= s6_up_q;
            out_lo_q    <= s6_lo_q;
        end
    end

    assign bf_upper  = out_up_q;
    assign bf_lower  = out_lo_q;
    assign valid_out = out_valid_q;

`ifndef SYNTHESIS
    // Operands at or above q break the modular arithmetic silently.
    always @(posedge clk) begin
        if (rst && valid_in) begin
            assert (a < Q_N && b < Q_N && w < Q_N)
                else $error("butterfly_pipe: operand out of range a=%0d b=%0d w=%0d", a, b, w);
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_pipe.sv
module tb_butterfly_pipe;

    localparam int W  = 14;
    localparam int QI = 12289;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] w = '0;
    logic [W-1:0] bf_upper, bf_lower;
    logic         valid_out;

    butterfly_pipe #(.data_width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .w         (w),
        .bf_upper  (bf_upper),
        .bf_lower  (bf_lower),
        .valid_out (valid_out)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [W-1:0] up;
        logic [W-1:0] lo;
        logic [31:0]  cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   zero_win = 1'b1;   // outputs must read 0 until the first result after reset

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Division by 2 mod q is multiplication by (q+1)/2.
    function automatic int gs_scale(input int x);
`ifdef BFU_GS_DIV2_EN
        return (x * ((QI + 1) / 2)) % QI;
`else
        return x;
`endif
    endfunction

    task automatic ref_model(input logic md, input int ai, input int bi, input int wi,
                             output int up, output int lo);
        int t;
        if (md == 1'b0) begin
            t  = (wi * bi) % QI;
            up = (ai + t) % QI;
            lo = (ai - t + QI) % QI;
        end else begin
            up = gs_scale((ai + bi) % QI);
            lo = gs_scale((((ai - bi + QI) % QI) * wi) % QI);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic md, input int ai, input int bi, input int wi,
                        input int eu, input int el);
        valid_in = 1'b1;
        mode     = md;
        a        = W'(ai);
        b        = W'(bi);
        w        = W'(wi);
        exp_q.push_back(exp_t'{up: W'(eu), lo: W'(el), cyc: cyc + 7});
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input logic md, input int ai, input int bi, input int wi);
        int eu, el;
        ref_model(md, ai, bi, wi, eu, el);
        send(md, ai, bi, wi, eu, el);
    endtask

    task automatic send_random(input logic md);
        send_model(md, int'($urandom_range(0, QI - 1)), int'($urandom_range(0, QI - 1)),
                   int'($urandom_range(0, QI - 1)));
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        w        = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && int'(exp_q[0].cyc) < int'(cyc)) begin
            e = exp_q.pop_front();
            check("missing_valid_out", 0, 1);
        end
        if (valid_out) begin
            zero_win = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("latency_cycle", int'(cyc), int'(e.cyc));
                check("bf_upper", int'(bf_upper), int'(e.up));
                check("bf_lower", int'(bf_lower), int'(e.lo));
            end
        end else if (zero_win) begin
            check("post_reset_upper_zero", int'(bf_upper), 0);
            check("post_reset_lower_zero", int'(bf_lower), 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_upper", int'(bf_upper), 0);
        check("reset_lower", int'(bf_lower), 0);
        check("reset_valid_out", int'(valid_out), 0);
        rst = 1'b1;

        // Directed vectors with hand-computed results
        send(1'b0, 1, 1, 1, 2, 0);
        send(1'b0, 0, 1, 12288, 12288, 1);
        send(1'b0, 12288, 12288, 12288, 0, 12287);
`ifdef BFU_GS_DIV2_EN
        send(1'b1, 5, 3, 2, 4, 2);
        send(1'b1, 3, 5, 1, 4, 12288);
`else
        send(1'b1, 5, 3, 2, 8, 4);
        send(1'b1, 3, 5, 1, 8, 12287);
`endif
        idle(10);

        // Back-to-back random samples, alternating CT / GS
        for (int i = 0; i < 300; i++) send_random(1'(i % 2));
        idle(10);

        // Reset in the middle of a stream
        for (int i = 0; i < 12; i++) send_random(1'(i % 2));
        rst      = 1'b0;
        valid_in = 1'b1;   // must be ignored while in reset
        mode     = 1'b0;
        a        = W'(7);
        b        = W'(9);
        w        = W'(11);
        @(posedge clk);
        #1;
        exp_q.delete();
        zero_win = 1'b1;
        rst      = 1'b1;
        for (int i = 0; i < 10; i++) send_random(1'($urandom_range(0, 1)));
        idle(2);

        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
